reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 32-entry x 32-bit general-purpose register file for the MIPS datapath.
- Two asynchronous read ports (rs, rt) feed the ALU and operand stage.
- One synchronous write port is driven from writeback.
- Register $0 is hardwired to zero.
- This block is the read/write counterpart to the datapath's pipeline and state registers: it holds architectural state and serves two consumers per cycle.

Parameters:
- DATA_W, 32, width of each register and each data port.
- ADDR_W, 5, width of register address ports.
- NREGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  clock; writes occur on the rising edge.
- reset  input  1  asynchronous, active-high; clears all registers.
- wr_en  input  1  write enable for the write port.
- wr_addr  input  ADDR_W  destination register index.
- wr_data  input  DATA_W  data to write.
- rs_addr  input  ADDR_W  read port A index.
- rt_addr  input  ADDR_W  read port B index.
- rs_data  output  DATA_W  contents of register rs_addr.
- rt_data  output  DATA_W  contents of register rt_addr.

Behaviour:
- Reset:
  - reset=1 asynchronously forces all NREGS registers to 0, regardless of clk.
  - While reset is held, rs_data=rt_data=0 for every address.
  - Writes are ignored while reset=1, including a clock edge coinciding with reset.
  - Release of reset takes effect immediately; the first rising edge with reset=0 may write.
- Write:
  - On posedge clk with reset=0, wr_en=1 and wr_addr!=0: reg[wr_addr] <= wr_data.
  - wr_en=0 leaves all registers unchanged.
- Register 0:
  - Writes to address 0 are discarded; no storage is required for entry 0.
  - rs_data/rt_data are always 0 when the corresponding address is 0, in every mode.
- Read:
  - Combinational, zero-cycle latency: rs_data = reg[rs_addr], rt_data = reg[rt_addr].
  - Both ports are independent; rs_addr==rt_addr returns identical data on both.
- Read/write collision (same address in the same cycle, macro absent):
  - The read returns the old value until the clock edge.
  - The new value is visible from the cycle after the write.
- Timing: no state machine; each storage row is an enabled 32-bit register. The address decode is one-hot from wr_addr gated by wr_en.
- Width rules:
  - No arithmetic.
  - Addresses are fully decoded; all 32 indices are valid.
  - Data is stored and returned unmodified, with no sign handling.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If wr_en=1, wr_addr!=0, reset=0 and rs_addr==wr_addr, then rs_data=wr_data combinationally in the same cycle. The same rule applies to rt.
  - Address 0 is never forwarded.
  - This supports writeback/decode in the same cycle without a half-cycle clock.
- Not defined: no forwarding; collision behaviour is as described under Behaviour.
- Storage contents after the clock edge are identical in both builds.

Decomposition:
- Shared package (mips_pkg or a common include): DATA_W=32, ADDR_W=5, NREGS=32, REG_ZERO=5'd0.
- Sub-module reg_en_word: a DATA_W register with async active-high reset and write enable. It is instantiated NREGS-1 times in a generate loop for entries 1..31.
- The read muxes stay inline in reg_file.

Test Plan:
- Assert reset mid-simulation after writing reg[5]=32'hDEADBEEF, between clock edges → rs_data at rs_addr=5 drops to 0 immediately, without waiting for a clk edge. All 32 addresses read 0.
- Write wr_addr=0, wr_data=32'hFFFFFFFF, wr_en=1 → rs_addr=0 and rt_addr=0 read 32'h0 on the next cycle and thereafter.
- Write reg[1]=32'h12345678, then reg[31]=32'hAFAFAFAF on consecutive edges → rs_addr=1 gives 32'h12345678, rt_addr=31 gives 32'hAFAFAFAF, and both ports at 31 give the same value.
- wr_en=0, wr_addr=7, wr_data=32'h55555555 with reg[7] previously 32'h1 → reg[7] stays 32'h1.
- Collision: reg[9]=32'hA, then in one cycle wr_addr=9, wr_data=32'hB, rs_addr=9:
  - without REGFILE_BYPASS_EN, rs_data=32'hA before the edge and 32'hB after;
  - with REGFILE_BYPASS_EN, rs_data=32'hB before the edge.
- Reset coinciding with a write edge: reset=1 on a posedge with wr_en=1, wr_addr=3, wr_data=32'h77 → reg[3] reads 0 after reset is released.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared sizing constants for the MIPS general-purpose register file.
// Imported by reg_file and reg_en_word.
package reg_file_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NREGS  = 32;

  // Architectural zero register index
  localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_reg_en_word.sv
// One register-file storage row: a DATA_W register with write enable
// and asynchronous active-high clear.
module reg_en_word
  import reg_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (en_i) begin
      word_d = d_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/reg_file.sv
// 32x32 MIPS register file: two combinational read ports, one clocked write
// port, $0 hardwired to zero. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREGS  = RF_NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  logic [DATA_W-1:0] words [NREGS];
  logic [NREGS-1:1]  wr_sel;

  // One-hot write decode; entry 0 has no storage, so it is never selected
  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < NREGS; i++) begin
      wr_sel[i] = wr_en && (wr_addr == ADDR_W'(i));
    end
  end

  assign words[0] = '0;

  for (genvar g = 1; g < NREGS; g++) begin : g_row
    reg_en_word #(
      .DATA_W (DATA_W)
    ) u_row (
      .clk_i (clk),
      .rst_i (reset),
      .en_i  (wr_sel[g]),
      .d_i   (wr_data),
      .q_o   (words[g])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_live;
  logic rs_fwd;
  logic rt_fwd;

  assign wr_live = wr_en && !reset && (wr_addr != ADDR_W'(REG_ZERO));
  assign rs_fwd  = wr_live && (rs_addr == wr_addr);
  assign rt_fwd  = wr_live && (rt_addr == wr_addr);

  assign rs_data = rs_fwd ? wr_data : words[rs_addr];
  assign rt_data = rt_fwd ? wr_data : words[rt_addr];
`else
  assign rs_data = words[rs_addr];
  assign rt_data = words[rt_addr];
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (default and REGFILE_BYPASS_EN builds).
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  int vectors;
  int miscompares;

  reg_file dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    rs_addr = a;
    rt_addr = b;
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rs_addr = '0;
    rt_addr = '0;
    repeat (2) @(posedge clk);
    #1;

    rd(5'd5, 5'd31);
    chk("reset_rs5", rs_data, 32'h0);
    chk("reset_rt31", rt_data, 32'h0);

    @(negedge clk);
    reset = 1'b0;

    // Async reset between edges after writing reg[5]
    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd5);
    chk("wr5_rs", rs_data, 32'hDEADBEEF);
    chk("wr5_rt", rt_data, 32'hDEADBEEF);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_rs5", rs_data, 32'h0);
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      chk("reset_all_rs", rs_data, 32'h0);
      chk("reset_all_rt", rt_data, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Writes to $0 are discarded
    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0);
    chk("zero_rs", rs_data, 32'h0);
    chk("zero_rt", rt_data, 32'h0);
    @(posedge clk);
    #1;
    chk("zero_rs_later", rs_data, 32'h0);

    // Consecutive writes to both ends of the address range
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h12345678;
    @(negedge clk);
    wr_addr = 5'd31; wr_data = 32'hAFAFAFAF;
    @(negedge clk);
    wr_en = 1'b0;
    rd(5'd1, 5'd31);
    chk("r1_rs", rs_data, 32'h12345678);
    chk("r31_rt", rt_data, 32'hAFAFAFAF);
    rd(5'd31, 5'd31);
    chk("r31_both_rs", rs_data, 32'hAFAFAFAF);
    chk("r31_both_rt", rt_data, 32'hAFAFAFAF);
    rd(5'd2, 5'd1);
    chk("r2_untouched", rs_data, 32'h0);
    chk("r1_rt", rt_data, 32'h12345678);

    // wr_en=0 must not disturb storage
    wr(5'd7, 32'h1);
    @(negedge clk);
    wr_en = 1'b0; wr_addr = 5'd7; wr_data = 32'h55555555;
    @(posedge clk);
    #1;
    rd(5'd7, 5'd7);
    chk("noen_r7", rs_data, 32'h1);

    // Read/write collision on reg[9]
    wr(5'd9, 32'hA);
    @(negedge clk);
    rs_addr = 5'd9; rt_addr = 5'd1;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hB;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("collide_pre", rs_data, 32'hB);
`else
    chk("collide_pre", rs_data, 32'hA);
`endif
    chk("collide_other_port", rt_data, 32'h12345678);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    #1;
    chk("collide_post", rs_data, 32'hB);

    // $0 is never forwarded
    @(negedge clk);
    rs_addr = 5'd0; rt_addr = 5'd0;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hCAFEF00D;
    #1;
    chk("zero_nofwd_rs", rs_data, 32'h0);
    chk("zero_nofwd_rt", rt_data, 32'h0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;

    // Reset coinciding with a write edge
    @(negedge clk);
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
    @(posedge clk);
    #1;
    @(negedge clk);
    wr_en = 1'b0;
    reset = 1'b0;
    rd(5'd3, 5'd1);
    chk("reset_edge_r3", rs_data, 32'h0);
    chk("reset_edge_r1", rt_data, 32'h0);

    // First edge after release may write
    wr(5'd3, 32'h0BADC0DE);
    rd(5'd9, 5'd3);
    chk("post_reset_r9", rs_data, 32'h0);
    chk("post_reset_r3", rt_data, 32'h0BADC0DE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
